// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and constants for the systolic array feeder.
package systolic_pkg;
  localparam int SYS_COLS = 2;
  typedef logic [15:0] fixed16_t;
  typedef enum logic [1:0] {IDLE, CFG, STREAM, DRAIN} feeder_state_t;
  function automatic fixed16_t to_fixed(input real v);
    return fixed16_t'($rtoi(v * 256.0));
  endfunction
endpackage

// File: rtl/systolic_feeder_skew.sv
// systolic_feeder_skew: one-cycle zero-filled delay turning column-1-timed streams into column-2 timing.
module systolic_feeder_skew
  import systolic_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk) r_q <= !rst ? '0 : i_d;
  assign o_q = r_q;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skewed weight/activation driver for the 2x2 systolic array.
// Optional drain watchdog and x1 overflow check under SYSTOLIC_FEEDER_TIMEOUT_EN.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MAX_M   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [$clog2(MAX_M)-1:0]   wr_row,
  input  logic                       wr_col,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       cmd_start,
  input  logic [$clog2(MAX_M+1)-1:0] cmd_m,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [15:0]                ub_rd_col_size_in,
  output logic                       ub_rd_col_size_valid_in,
  output logic [DATA_W-1:0]          sys_weight_in_x1,
  output logic [DATA_W-1:0]          sys_weight_in_x2,
  output logic                       sys_accept_w_1,
  output logic                       sys_accept_w_2,
  output logic                       sys_switch_in,
  output logic [DATA_W-1:0]          sys_data_in_1x,
  output logic [DATA_W-1:0]          sys_data_in_2x,
  output logic                       sys_start,
  input  logic                       sys_valid_out_x1,
  input  logic                       sys_valid_out_x2
);
  localparam int AW = $clog2(MAX_M);
  localparam int MW = $clog2(MAX_M + 1);
  localparam int TW = $clog2(MAX_M + 3);
  localparam int CW = 2 * DATA_W + 1;
  feeder_state_t r_state, w_next;
  logic [DATA_W-1:0] r_w [2][2];
  logic [DATA_W-1:0] r_a [MAX_M][2];
  logic [MW-1:0] r_m, r_cnt2, w_cnt2_nx;
  logic [TW-1:0] r_t, w_tm1;
  logic [AW-1:0] w_ai;
  logic [DATA_W-1:0] w_w2, w_a2;
  logic [CW-1:0] w_col2, w_col2_q;
  logic r_done, r_err, w_run, w_m_ok, w_beat2, w_fin, w_fail, w_t0, w_t1, w_act, w_unused;
  assign w_run     = r_state == STREAM || r_state == DRAIN;
  assign w_m_ok    = cmd_m != '0 && cmd_m <= MW'(MAX_M);
  assign w_beat2   = w_run && sys_valid_out_x2 && r_cnt2 != r_m;
  assign w_cnt2_nx = r_cnt2 + MW'(w_beat2);
  assign w_fin     = r_state == DRAIN && !r_done && !r_err && w_cnt2_nx == r_m;
  // Buffers have no reset so their contents survive an aborted run.
  always_ff @(posedge clk)
    if (wr_en && r_state == IDLE) begin
      if (wr_sel) r_a[wr_row][wr_col] <= wr_data;
      else r_w[wr_row[0]][wr_col] <= wr_data;
    end
  always_ff @(posedge clk) r_state <= !rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = cmd_start && w_m_ok ? CFG : IDLE;
      CFG:     w_next = STREAM;
      STREAM:  w_next = r_err ? IDLE : r_t == TW'(r_m) + TW'(1) ? DRAIN : STREAM;
      default: w_next = r_done || r_err ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      r_m    <= '0;
      r_t    <= '0;
      r_cnt2 <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_m    <= r_state == IDLE && cmd_start && w_m_ok ? cmd_m : r_m;
      r_t    <= r_state == STREAM ? r_t + TW'(1) : '0;
      r_cnt2 <= r_state == IDLE ? '0 : w_cnt2_nx;
      r_done <= w_fin;
      r_err  <= (r_state == IDLE && cmd_start && !w_m_ok) || w_fail;
    end
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] r_wd;
  logic [MW-1:0] r_cnt1;
  assign w_fail = w_run && !r_done && !r_err && !w_fin &&
                  ((r_state == DRAIN && r_wd == WDW'(TIMEOUT - 1)) || (sys_valid_out_x1 && r_cnt1 == r_m));
  always_ff @(posedge clk)
    if (!rst) begin
      r_wd   <= '0;
      r_cnt1 <= '0;
    end else begin
      r_wd   <= r_state == DRAIN ? r_wd + WDW'(1) : '0;
      r_cnt1 <= r_state == IDLE ? '0 : r_cnt1 + MW'(w_run && sys_valid_out_x1 && r_cnt1 != r_m);
    end
  assign w_unused = ^w_tm1[TW-1:AW];
`else
  assign w_fail   = 1'b0;
  assign w_unused = ^{w_tm1[TW-1:AW], sys_valid_out_x1, TIMEOUT[0]};
`endif
  assign w_t0   = r_state == STREAM && r_t == '0;
  assign w_t1   = r_state == STREAM && r_t == TW'(1);
  assign w_act  = r_state == STREAM && r_t != '0 && r_t <= TW'(r_m);
  assign w_tm1  = r_t - TW'(1);
  assign w_ai   = w_tm1[AW-1:0];
  assign w_w2   = w_t0 ? r_w[1][1] : w_t1 ? r_w[0][1] : '0;
  assign w_a2   = w_act ? r_a[w_ai][1] : '0;
  // Column 2 is column 1's schedule shifted by one cycle.
  assign w_col2 = {w_w2, w_t0 || w_t1, w_a2};
  systolic_feeder_skew #(.W(CW)) u_skew (
    .clk (clk),
    .rst (rst),
    .i_d (w_col2),
    .o_q (w_col2_q)
  );
  always_comb begin
    busy                    = r_state != IDLE;
    done                    = r_done;
    err                     = r_err;
    ub_rd_col_size_valid_in = r_state != IDLE;
    ub_rd_col_size_in       = r_state != IDLE ? 16'(SYS_COLS) : '0;
    sys_weight_in_x1        = w_t0 ? r_w[1][0] : w_t1 ? r_w[0][0] : '0;
    sys_accept_w_1          = w_t0 || w_t1;
    {sys_weight_in_x2, sys_accept_w_2, sys_data_in_2x} = w_col2_q;
    sys_switch_in           = w_col2_q[DATA_W];
    sys_data_in_1x          = w_act ? r_a[w_ai][0] : '0;
    sys_start               = w_act;
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed self-checking bench for systolic_feeder.
module tb_systolic_feeder;
  import systolic_pkg::*;
  localparam int DATA_W = 16;
  localparam int MAX_M = 8;
  localparam int TIMEOUT = 64;
  logic clk = 0, rst = 0, wr_en = 0, wr_sel = 0, wr_col = 0, cmd_start = 0, vx1 = 0, vx2 = 0;
  logic [2:0] wr_row = 0;
  logic [15:0] wr_data = 0;
  logic [3:0] cmd_m = 0;
  logic busy, done, err, col_valid, acc1, acc2, sw, st;
  logic [15:0] col_size, wx1, wx2, d1, d2;
  logic [87:0] all_out;
  logic [67:0] strm;
  int checks = 0, failures = 0;

  systolic_feeder #(.DATA_W(DATA_W), .MAX_M(MAX_M), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .cmd_start(cmd_start), .cmd_m(cmd_m), .busy(busy), .done(done), .err(err),
    .ub_rd_col_size_in(col_size), .ub_rd_col_size_valid_in(col_valid),
    .sys_weight_in_x1(wx1), .sys_weight_in_x2(wx2), .sys_accept_w_1(acc1), .sys_accept_w_2(acc2),
    .sys_switch_in(sw), .sys_data_in_1x(d1), .sys_data_in_2x(d2), .sys_start(st),
    .sys_valid_out_x1(vx1), .sys_valid_out_x2(vx2)
  );

  always #5 clk = ~clk;
  assign all_out = {busy, done, err, col_size, col_valid, wx1, wx2, acc1, acc2, sw, d1, d2, st};
  assign strm = {wx1, wx2, d1, d2, acc1, acc2, sw, st};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [2:0] row, input logic col, input logic [15:0] d);
    wr_en = 1; wr_sel = sel; wr_row = row; wr_col = col; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic launch(input logic [3:0] m);
    cmd_start = 1; cmd_m = m;
    tick();
    cmd_start = 0;
  endtask

  task automatic end_run();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic load_buffers();
    wr(0, 0, 0, to_fixed(1.0));
    wr(0, 0, 1, 16'h0459);
    wr(0, 1, 0, to_fixed(5.75));
    wr(0, 1, 1, to_fixed(1.0));
    wr(1, 0, 0, to_fixed(1.0));
    wr(1, 0, 1, to_fixed(2.0));
    wr(1, 1, 0, to_fixed(5.0));
    wr(1, 1, 1, to_fixed(6.0));
  endtask

  task automatic test_reset();
    rst = 0;
    tick();
    tick();
    checks++;
    if (all_out !== 88'd0) begin failures++; $display("FAIL reset outputs: got %h expected 0", all_out); end
    rst = 1;
  endtask

  task automatic test_stream();
    logic [67:0] exp [5];
    exp[0] = {16'h05C0, 16'h0000, 16'h0000, 16'h0000, 4'b1000};
    exp[1] = {16'h0100, 16'h0100, 16'h0100, 16'h0000, 4'b1111};
    exp[2] = {16'h0000, 16'h0459, 16'h0500, 16'h0200, 4'b0111};
    exp[3] = {16'h0000, 16'h0000, 16'h0000, 16'h0600, 4'b0000};
    exp[4] = 68'd0;
    launch(2);
    checks++;
    if ({busy, col_size, col_valid} !== {1'b1, 16'd2, 1'b1}) begin
      failures++; $display("FAIL cfg: got busy=%b col=%0d valid=%b expected 1/2/1", busy, col_size, col_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (strm !== exp[i]) begin failures++; $display("FAIL stream t%0d: got %h expected %h", i, strm, exp[i]); end
    end
    checks++;
    if ({busy, col_size} !== {1'b1, 16'd2}) begin failures++; $display("FAIL drain busy: got %b/%0d expected 1/2", busy, col_size); end
    end_run();
  endtask

  task automatic test_done();
    launch(2);
    repeat (5) tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done early d0: got %b expected 0", done); end
    vx2 = 1;
    tick();
    checks++;
    if ({done, busy} !== 2'b01) begin failures++; $display("FAIL done after beat1: got done=%b busy=%b expected 0/1", done, busy); end
    tick();
    vx2 = 0;
    checks++;
    if ({done, busy, err} !== 3'b110) begin failures++; $display("FAIL done pulse: got done=%b busy=%b err=%b expected 1/1/0", done, busy, err); end
    tick();
    checks++;
    if (all_out !== 88'd0) begin failures++; $display("FAIL after done: got %h expected 0", all_out); end
  endtask

  task automatic test_illegal();
    logic [3:0] bad [2];
    bad[0] = 4'd0;
    bad[1] = 4'(MAX_M + 1);
    for (int i = 0; i < 2; i++) begin
      launch(bad[i]);
      checks++;
      if (all_out !== {3'b001, 85'd0}) begin failures++; $display("FAIL illegal m=%0d: got %h expected err only", bad[i], all_out); end
      tick();
      checks++;
      if (all_out !== 88'd0) begin failures++; $display("FAIL illegal m=%0d after: got %h expected 0", bad[i], all_out); end
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] exp [4];
    int starts;
    exp[0] = {16'h0000, 1'b0};
    exp[1] = {16'h0100, 1'b1};
    exp[2] = {16'h0000, 1'b0};
    exp[3] = {16'h0000, 1'b0};
    launch(2);
    repeat (3) tick();
    rst = 0;
    tick();
    rst = 1;
    checks++;
    if (all_out !== 88'd0) begin failures++; $display("FAIL mid reset: got %h expected 0", all_out); end
    launch(1);
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      starts += int'(st);
      checks++;
      if ({d1, st} !== exp[i]) begin failures++; $display("FAIL m1 t%0d: got d1=%h st=%b expected %h", i, d1, st, exp[i]); end
      if (i == 2) begin
        checks++;
        if (d2 !== 16'h0200) begin failures++; $display("FAIL m1 d2 t2: got %h expected 0200", d2); end
      end
    end
    checks++;
    if (starts !== 1) begin failures++; $display("FAIL m1 start count: got %0d expected 1", starts); end
    end_run();
  endtask

  task automatic test_write_busy();
    launch(2);
    wr(0, 1, 0, 16'hFFFF);
    wr(1, 0, 0, 16'hFFFF);
    wr(0, 1, 1, 16'hFFFF);
    end_run();
    launch(2);
    tick();
    checks++;
    if (wx1 !== 16'h05C0) begin failures++; $display("FAIL busy write w10: got %h expected 05C0", wx1); end
    tick();
    checks++;
    if ({d1, wx2} !== {16'h0100, 16'h0100}) begin failures++; $display("FAIL busy write a00/w11: got %h/%h expected 0100/0100", d1, wx2); end
    end_run();
  endtask

  task automatic test_write_first();
    wr_en = 1; wr_sel = 0; wr_row = 1; wr_col = 0; wr_data = 16'h1234;
    launch(1);
    wr_en = 0;
    tick();
    checks++;
    if (wx1 !== 16'h1234) begin failures++; $display("FAIL write+start: got %h expected 1234", wx1); end
    end_run();
    wr(0, 1, 0, 16'h05C0);
  endtask

  task automatic test_drain_wait();
    launch(1);
    repeat (4) tick();
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    for (int k = 0; k <= TIMEOUT; k++) begin
      checks++;
      if (k < TIMEOUT && {err, done} !== 2'b00) begin
        failures++; $display("FAIL watchdog early k=%0d: got err=%b done=%b expected 0/0", k, err, done);
      end else if (k == TIMEOUT && {err, done, busy} !== 3'b101) begin
        failures++; $display("FAIL watchdog fire: got err=%b done=%b busy=%b expected 1/0/1", err, done, busy);
      end
      if (k < TIMEOUT) tick();
    end
    tick();
    checks++;
    if (all_out !== 88'd0) begin failures++; $display("FAIL after timeout: got %h expected 0", all_out); end
`else
    for (int k = 0; k < TIMEOUT + 16; k++) begin
      checks++;
      if ({err, done, busy} !== 3'b001) begin
        failures++; $display("FAIL drain wait k=%0d: got err=%b done=%b busy=%b expected 0/0/1", k, err, done, busy);
      end
      tick();
    end
`endif
    end_run();
  endtask

  initial begin
    test_reset();
    load_buffers();
    test_stream();
    test_done();
    test_illegal();
    test_reset_mid();
    test_write_busy();
    test_write_first();
    test_drain_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Transmit-side driver for the 2x2 systolic array. It buffers a 2x2 weight matrix W and an Mx2 activation matrix A (fixed-point 8.8, 16-bit), written by the host or unified-buffer controller. On command it emits the skewed weight-load, switch, start and activation streams on the array's left and top edges, then counts column-2 valid results to report completion. It sits between the unified buffer and the array's top and left ports.

Parameters:
DATA_W, 16, activation/weight width (8.8 fixed point)
MAX_M, 8, maximum activation rows per run
TIMEOUT, 64, drain watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
wr_en  in  1  buffer write strobe
wr_sel  in  1  0=weight, 1=activation
wr_row  in  $clog2(MAX_M)  row index (weights use 0..1)
wr_col  in  1  column index
wr_data  in  DATA_W  write data
cmd_start  in  1  start a run (sampled only in IDLE)
cmd_m  in  $clog2(MAX_M+1)  row count M
busy  out  1  high from run accept until done/err
done  out  1  one-cycle pulse at run end
err  out  1  one-cycle pulse on illegal M or timeout
ub_rd_col_size_in  out  16  active column count, always 2 when valid
ub_rd_col_size_valid_in  out  1  column-size valid
sys_weight_in_x1 / sys_weight_in_x2  out  DATA_W  top weight inputs
sys_accept_w_1 / sys_accept_w_2  out  1  weight accept per column
sys_switch_in  out  1  weight switch
sys_data_in_1x / sys_data_in_2x  out  DATA_W  left activation inputs
sys_start  out  1  stream start/valid
sys_valid_out_x1 / sys_valid_out_x2  in  1  array bottom valids

Behaviour:
- Reset (rst=0 at posedge): all outputs 0; state IDLE; buffers keep their contents. Reset mid-run aborts at once with no done or err.
- Writes: accepted only in IDLE. Writes while busy are ignored. Write and start in the same cycle: the write lands first, the run uses the new data.
- IDLE to CFG: on cmd_start with 1<=cmd_m<=MAX_M. M is latched, busy=1.
- Illegal cmd_m (0 or >MAX_M): err pulses one cycle, no state change.
- CFG (1 cycle): col_size=2, col_size_valid=1. Both hold until leaving DRAIN.
- Stream phase, t=0..M+1:
  - t=0: accept_w_1=1, w_x1=W[1][0].
  - t=1: w_x1=W[0][0], accept_w_2=1, w_x2=W[1][1], switch=1.
  - t=2: accept_w_1=0, w_x2=W[0][1].
  - t=3: accept_w_2=0, switch=0.
  - sys_start=1 for t=1..M.
  - data_1x=A[t-1][0] for t=1..M.
  - data_2x=A[t-2][1] for t=2..M+1.
  - Every data/weight output is 0 when not driven by the rules above.
- DRAIN: counts sys_valid_out_x2 beats, starting from t=0 (it does not wait for the end of STREAM). At M beats: done pulses, busy drops, back to IDLE. sys_valid_out_x1 is monitored only by the optional feature.
- No arithmetic is performed. Data is passed through bit-exact.

Optional Feature:
SYSTOLIC_FEEDER_TIMEOUT_EN
- Defined:
  - A watchdog counts DRAIN cycles.
  - At TIMEOUT cycles: err pulses, done stays low, return to IDLE.
  - Valid beats on x1 beyond M also raise err.
- Undefined: DRAIN waits indefinitely and x1 is ignored.

Decomposition:
- Shared package systolic_pkg holds:
  - fixed16_t
  - feeder state enum (IDLE, CFG, STREAM, DRAIN)
  - SYS_COLS=2 constant
  - to_fixed helper for benches
- One natural sub-module: systolic_feeder_skew, a one-cycle delay register with zero-fill that produces column-2 streams from column-1 timing.

Test Plan:
1. Load W={{0x0100,0x0459},{0x05C0,0x0100}} and A={{0x0100,0x0200},{0x0500,0x0600}}, start M=2 -> t0: w_x1=0x05C0; t1: w_x1=0x0100, w_x2=0x0100, data_1x=0x0100; t2: w_x2=0x0459, data_1x=0x0500, data_2x=0x0200; t3: data_2x=0x0600.
2. Same run, bench drives 2 x2-valid beats -> done pulses exactly one cycle after the second beat; busy low the cycle after.
3. cmd_m=0 and cmd_m=MAX_M+1 -> err pulse, busy stays 0, outputs stay 0.
4. Assert rst=0 at t=2 -> all outputs 0 the next cycle; a new M=1 run then gives data_1x=A[0][0] at t=1 only and sys_start high for one cycle.
5. wr_en during busy with data 0xFFFF -> ignored; the next run streams the original values.
6. With SYSTOLIC_FEEDER_TIMEOUT_EN defined and no valids -> err pulses TIMEOUT cycles into DRAIN and done never asserts.
